// File: rtl/mem_port_arbiter_if.sv
// Bundle between NUM_PORTS requesters, the shared-memory arbiter and the memory itself.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]          req;
    logic [NUM_PORTS-1:0]          we;
    logic [NUM_PORTS*ADDR_W-1:0]   addr;
    logic [NUM_PORTS*DATA_W-1:0]   wdata;
    logic [NUM_PORTS*DATA_W/8-1:0] be;
    logic [NUM_PORTS-1:0]          gnt;
    logic [NUM_PORTS-1:0]          stall;
    logic [NUM_PORTS-1:0]          rsp_valid;
    logic [DATA_W-1:0]             rdata;
    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic [DATA_W/8-1:0]           mem_be;
    logic [DATA_W-1:0]             mem_rdata;
    logic [31:0]                   conflict_count;

    modport slave (
        input  req, we, addr, wdata, be, mem_rdata,
        output gnt, stall, rsp_valid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, conflict_count
    );

    modport master (
        output req, we, addr, wdata, be, mem_rdata,
        input  gnt, stall, rsp_valid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, conflict_count
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory among NUM_PORTS requesters: one grant per
// cycle, stall for every loser, optional starvation guard and saturating conflict count.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RR_MODE   = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int BW = DATA_W / 8;

    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]        wait_q [NUM_PORTS];
    logic [WW-1:0]        wait_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] rsp_q, rsp_d;
    logic [31:0]          conflict_q, conflict_d;

    logic [NUM_PORTS-1:0] gnt;
    logic [PW-1:0]        win;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [BW-1:0]        mem_be;

    // Starvation guard first, then the mode's own priority; the first hit wins.
    always_comb begin : sel
        logic          found;
        logic [PW-1:0] cand;
        found = 1'b0;
        cand  = '0;
        win   = '0;
        gnt   = '0;
        if (!rst) begin
            if (RR_MODE == 0 && MAX_WAIT > 0) begin
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (!found && bus.req[i] && wait_q[i] == WW'(MAX_WAIT)) begin
                        found = 1'b1;
                        win   = PW'(i);
                    end
                end
            end
            if (!found && RR_MODE == 0) begin
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (!found && bus.req[i]) begin
                        found = 1'b1;
                        win   = PW'(i);
                    end
                end
            end
            if (!found && RR_MODE != 0) begin
                for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                    cand = PW'((32'(rr_ptr_q) + j) % 32'(NUM_PORTS));
                    if (!found && bus.req[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
            end
            if (found) gnt[win] = 1'b1;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (|gnt) begin
            mem_we    = bus.we[win];
            mem_addr  = bus.addr[32'(win)*ADDR_W +: ADDR_W];
            mem_wdata = bus.wdata[32'(win)*DATA_W +: DATA_W];
            mem_be    = bus.be[32'(win)*BW +: BW];
        end
    end

    always_comb begin
        int unsigned nreq;
        nreq     = 0;
        rr_ptr_d = rr_ptr_q;
        if (|gnt) rr_ptr_d = (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            wait_d[i] = wait_q[i];
            if (!bus.req[i] || gnt[i])
                wait_d[i] = '0;
            else if (wait_q[i] != WW'(MAX_WAIT))
                wait_d[i] = wait_q[i] + 1'b1;
            nreq = nreq + 32'(bus.req[i]);
        end
        rsp_d      = gnt & ~bus.we;
        conflict_d = conflict_q;
        if (nreq >= 2 && conflict_q != '1) conflict_d = conflict_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rsp_q      <= '0;
            conflict_q <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) wait_q[i] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_q      <= rsp_d;
            conflict_q <= conflict_d;
            for (int unsigned i = 0; i < NUM_PORTS; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign bus.gnt            = gnt;
    assign bus.stall          = bus.req & ~gnt;
    assign bus.rsp_valid      = rsp_q;
    assign bus.rdata          = bus.mem_rdata;
    assign bus.mem_en         = |gnt;
    assign bus.mem_we         = mem_we;
    assign bus.mem_addr       = mem_addr;
    assign bus.mem_wdata      = mem_wdata;
    assign bus.mem_be         = mem_be;
    assign bus.conflict_count = conflict_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations (fixed/no guard, round-robin x3,
// fixed with MAX_WAIT=2) checked each cycle against a rule-level reference model.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) if0 ();
    mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) if1 ();
    mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) if2 ();

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .MAX_WAIT(0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .MAX_WAIT(4))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .MAX_WAIT(2))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    // Stimulus, per DUT and port
    logic [7:0]  s_req [3];
    logic [7:0]  s_we  [3];
    logic [31:0] s_addr[3][8];
    logic [31:0] s_wd  [3][8];
    logic [3:0]  s_be  [3][8];

    assign if0.req = s_req[0][1:0];
    assign if0.we  = s_we[0][1:0];
    assign if1.req = s_req[1][2:0];
    assign if1.we  = s_we[1][2:0];
    assign if2.req = s_req[2][1:0];
    assign if2.we  = s_we[2][1:0];
    for (genvar p = 0; p < 2; p++) begin : g_if0
        assign if0.addr[p*32 +: 32]  = s_addr[0][p];
        assign if0.wdata[p*32 +: 32] = s_wd[0][p];
        assign if0.be[p*4 +: 4]      = s_be[0][p];
        assign if2.addr[p*32 +: 32]  = s_addr[2][p];
        assign if2.wdata[p*32 +: 32] = s_wd[2][p];
        assign if2.be[p*4 +: 4]      = s_be[2][p];
    end
    for (genvar p = 0; p < 3; p++) begin : g_if1
        assign if1.addr[p*32 +: 32]  = s_addr[1][p];
        assign if1.wdata[p*32 +: 32] = s_wd[1][p];
        assign if1.be[p*4 +: 4]      = s_be[1][p];
    end

    // Memory behind DUT0; the other two get random read data
    logic [31:0] mem0 [16];
    always @(posedge clk) begin
        if (if0.mem_en) begin
            if (if0.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (if0.mem_be[b]) mem0[if0.mem_addr[5:2]][b*8 +: 8] <= if0.mem_wdata[b*8 +: 8];
            end else begin
                if0.mem_rdata <= mem0[if0.mem_addr[5:2]];
            end
        end
    end
    always @(posedge clk) begin
        if1.mem_rdata <= $urandom;
        if2.mem_rdata <= $urandom;
    end

    // Observed outputs, zero-extended
    logic [7:0]  o_gnt[3], o_stall[3], o_rsp[3];
    logic [31:0] o_en[3], o_we[3], o_addr[3], o_wd[3], o_be[3], o_cc[3], o_rd[3], o_mrd[3];
    logic [31:0] o_ptr1, o_w2[2];

    assign o_gnt[0] = 8'(if0.gnt);   assign o_gnt[1] = 8'(if1.gnt);   assign o_gnt[2] = 8'(if2.gnt);
    assign o_stall[0] = 8'(if0.stall); assign o_stall[1] = 8'(if1.stall); assign o_stall[2] = 8'(if2.stall);
    assign o_rsp[0] = 8'(if0.rsp_valid); assign o_rsp[1] = 8'(if1.rsp_valid); assign o_rsp[2] = 8'(if2.rsp_valid);
    assign o_en[0] = 32'(if0.mem_en); assign o_en[1] = 32'(if1.mem_en); assign o_en[2] = 32'(if2.mem_en);
    assign o_we[0] = 32'(if0.mem_we); assign o_we[1] = 32'(if1.mem_we); assign o_we[2] = 32'(if2.mem_we);
    assign o_addr[0] = if0.mem_addr;  assign o_addr[1] = if1.mem_addr;  assign o_addr[2] = if2.mem_addr;
    assign o_wd[0] = if0.mem_wdata;   assign o_wd[1] = if1.mem_wdata;   assign o_wd[2] = if2.mem_wdata;
    assign o_be[0] = 32'(if0.mem_be); assign o_be[1] = 32'(if1.mem_be); assign o_be[2] = 32'(if2.mem_be);
    assign o_cc[0] = if0.conflict_count; assign o_cc[1] = if1.conflict_count; assign o_cc[2] = if2.conflict_count;
    assign o_rd[0] = if0.rdata;       assign o_rd[1] = if1.rdata;       assign o_rd[2] = if2.rdata;
    assign o_mrd[0] = if0.mem_rdata;  assign o_mrd[1] = if1.mem_rdata;  assign o_mrd[2] = if2.mem_rdata;
    assign o_ptr1  = 32'(u1.rr_ptr_q);
    assign o_w2[0] = 32'(u2.wait_q[0]);
    assign o_w2[1] = 32'(u2.wait_q[1]);

    // Reference model state
    int              np [3];
    bit              rrm[3];
    int              mw [3];
    int              ptr[3];
    int              wc [3][8];
    logic [7:0]      e_rsp[3];
    longint unsigned e_cc [3];

    logic [7:0] last_gnt[3];
    logic [7:0] last_stall[3];
    logic [31:0] last_we[3];
    int checks = 0;
    int errors = 0;

    logic [7:0] rr_seq[6] = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04};
    logic [7:0] st_seq[4] = '{8'h01, 8'h01, 8'h02, 8'h01};
    int         st_wc1[3] = '{1, 2, 0};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int winner(int d);
        if (rst || s_req[d] == 8'h00) return -1;
        if (!rrm[d] && mw[d] > 0)
            for (int i = 0; i < np[d]; i++)
                if (s_req[d][i] && wc[d][i] == mw[d]) return i;
        if (!rrm[d]) begin
            for (int i = 0; i < np[d]; i++) if (s_req[d][i]) return i;
        end else begin
            for (int j = 0; j < np[d]; j++) if (s_req[d][(ptr[d] + j) % np[d]]) return (ptr[d] + j) % np[d];
        end
        return -1;
    endfunction

    task automatic model_edge(int d, int w);
        if (rst) begin
            ptr[d] = 0;
            e_rsp[d] = 8'h00;
            e_cc[d] = 0;
            for (int i = 0; i < 8; i++) wc[d][i] = 0;
            return;
        end
        e_rsp[d] = 8'h00;
        if (w >= 0) begin
            ptr[d] = (w + 1) % np[d];
            if (!s_we[d][w]) e_rsp[d][w] = 1'b1;
        end
        for (int i = 0; i < np[d]; i++) begin
            if (!s_req[d][i] || i == w) wc[d][i] = 0;
            else if (wc[d][i] < mw[d]) wc[d][i]++;
        end
        if ($countones(s_req[d]) >= 2 && e_cc[d] < 64'hFFFF_FFFF) e_cc[d]++;
    endtask

    // One clock: compare combinational and registered outputs, then advance the model.
    task automatic cycle();
        int w[3];
        logic [7:0] eg;
        #1;
        for (int d = 0; d < 3; d++) begin
            w[d] = winner(d);
            eg = 8'h00;
            if (w[d] >= 0) eg[w[d]] = 1'b1;
            chk($sformatf("d%0d_gnt", d), 32'(o_gnt[d]), 32'(eg));
            chk($sformatf("d%0d_stall", d), 32'(o_stall[d]), 32'(s_req[d] & ~eg));
            chk($sformatf("d%0d_mem_en", d), o_en[d], 32'(w[d] >= 0));
            chk($sformatf("d%0d_mem_we", d), o_we[d], (w[d] >= 0) ? 32'(s_we[d][w[d]]) : 32'd0);
            chk($sformatf("d%0d_mem_addr", d), o_addr[d], (w[d] >= 0) ? s_addr[d][w[d]] : 32'd0);
            chk($sformatf("d%0d_mem_wdata", d), o_wd[d], (w[d] >= 0) ? s_wd[d][w[d]] : 32'd0);
            chk($sformatf("d%0d_mem_be", d), o_be[d], (w[d] >= 0) ? 32'(s_be[d][w[d]]) : 32'd0);
            chk($sformatf("d%0d_rsp_valid", d), 32'(o_rsp[d]), 32'(e_rsp[d]));
            chk($sformatf("d%0d_conflict", d), o_cc[d], 32'(e_cc[d]));
            chk($sformatf("d%0d_rdata", d), o_rd[d], o_mrd[d]);
            last_gnt[d]   = o_gnt[d];
            last_stall[d] = o_stall[d];
            last_we[d]    = o_we[d];
        end
        chk("d1_rr_ptr", o_ptr1, 32'(ptr[1]));
        chk("d2_wait0", o_w2[0], 32'(wc[2][0]));
        chk("d2_wait1", o_w2[1], 32'(wc[2][1]));
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_edge(d, w[d]);
        @(negedge clk);
    endtask

    task automatic clear_stim();
        for (int d = 0; d < 3; d++) begin
            s_req[d] = 8'h00;
            s_we[d]  = 8'h00;
            for (int p = 0; p < 8; p++) begin
                s_addr[d][p] = 32'h0;
                s_wd[d][p]   = 32'h0;
                s_be[d][p]   = 4'h0;
            end
        end
    endtask

    task automatic set_port(int d, int p, bit wr, logic [31:0] a, logic [31:0] wd, logic [3:0] b);
        s_req[d][p]  = 1'b1;
        s_we[d][p]   = wr;
        s_addr[d][p] = a;
        s_wd[d][p]   = wd;
        s_be[d][p]   = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        np  = '{2, 3, 2};
        rrm = '{1'b0, 1'b1, 1'b0};
        mw  = '{0, 4, 2};
        for (int d = 0; d < 3; d++) begin
            ptr[d] = 0;
            e_rsp[d] = 8'h00;
            e_cc[d] = 0;
            for (int i = 0; i < 8; i++) wc[d][i] = 0;
        end
        rst = 1'b1;
        clear_stim();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Requests during reset: no grant, every requester stalled
        set_port(0, 0, 1'b0, 32'h4, 32'h0, 4'hF);
        set_port(1, 1, 1'b1, 32'h8, 32'h1234, 4'h3);
        set_port(2, 1, 1'b0, 32'hC, 32'h0, 4'hF);
        cycle();
        chk("rst_gnt0", 32'(last_gnt[0]), 32'h0);
        chk("rst_stall1", 32'(last_stall[1]), 32'h2);
        chk("rst_cc", o_cc[0], 32'h0);
        chk("rst_rsp", 32'(o_rsp[0]), 32'h0);
        chk("rst_ptr", o_ptr1, 32'h0);
        chk("rst_wait", o_w2[1], 32'h0);
        rst = 1'b0;

        // Fixed priority, both ports reading
        clear_stim();
        set_port(0, 0, 1'b0, 32'h0, 32'h0, 4'hF);
        set_port(0, 1, 1'b0, 32'h4, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t1_gnt", 32'(last_gnt[0]), 32'h01);
            chk("t1_stall", 32'(last_stall[0]), 32'h02);
            chk("t1_rsp", 32'(o_rsp[0]), 32'h01);
        end
        chk("t1_conflicts", o_cc[0], 32'd3);

        // Round-robin rotation across three ports
        do_reset();
        clear_stim();
        for (int p = 0; p < 3; p++) set_port(1, p, 1'b0, 32'(p*4), 32'h0, 4'hF);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t2_rr_gnt", 32'(last_gnt[1]), 32'(rr_seq[k]));
        end

        // Starvation guard with MAX_WAIT = 2
        do_reset();
        clear_stim();
        set_port(2, 0, 1'b0, 32'h0, 32'h0, 4'hF);
        set_port(2, 1, 1'b0, 32'h4, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_gnt", 32'(last_gnt[2]), 32'(st_seq[k]));
            if (k < 3) chk("t3_wait1", o_w2[1], 32'(st_wc1[k]));
        end

        // Write then read back the same word
        do_reset();
        clear_stim();
        set_port(0, 1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        cycle();
        chk("t4_we_wr", last_we[0], 32'h1);
        chk("t4_no_wr_rsp", 32'(o_rsp[0]), 32'h0);
        clear_stim();
        set_port(0, 0, 1'b0, 32'h10, 32'h0, 4'hF);
        cycle();
        chk("t4_we_rd", last_we[0], 32'h0);
        chk("t4_rsp", 32'(o_rsp[0]), 32'h01);
        chk("t4_rdata", o_rd[0], 32'hDEAD_BEEF);

        // Reset arriving the cycle after a read grant drops the response
        clear_stim();
        set_port(0, 0, 1'b0, 32'h10, 32'h0, 4'hF);
        set_port(1, 0, 1'b0, 32'h0, 32'h0, 4'hF);
        cycle();
        chk("t5_ptr_pre", o_ptr1, 32'h1);
        rst = 1'b1;
        cycle();
        chk("t5_gnt_in_rst", 32'(last_gnt[0]), 32'h0);
        chk("t5_rsp", 32'(o_rsp[0]), 32'h0);
        chk("t5_cc", o_cc[0], 32'h0);
        chk("t5_ptr", o_ptr1, 32'h0);
        rst = 1'b0;

        // Conflict counter saturation
        clear_stim();
        set_port(0, 0, 1'b0, 32'h0, 32'h0, 4'hF);
        set_port(0, 1, 1'b0, 32'h4, 32'h0, 4'hF);
        force u0.conflict_q = 32'hFFFF_FFFE;
        #1;
        release u0.conflict_q;
        e_cc[0] = 64'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t6_sat", o_cc[0], 32'hFFFF_FFFF);
        end

        // Random traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            clear_stim();
            for (int d = 0; d < 3; d++) begin
                for (int p = 0; p < np[d]; p++) begin
                    if ($urandom_range(0, 3) != 0)
                        set_port(d, p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                                 $urandom, 4'($urandom_range(0, 15)));
                end
            end
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
